// File: rtl/lfsr_arb_pkg.sv
// Shared types, default tap masks and width helper for the LFSR random-word arbiter.
package lfsr_arb_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    SHIFT = 2'd1,
    ACK   = 2'd2
  } state_t;

  // Maximal-length masks for fb = ^(state & taps) shifted into the LSB.
  localparam logic [2:0]  TAPS_N3  = 3'b110;
  localparam logic [3:0]  TAPS_N4  = 4'b1100;
  localparam logic [7:0]  TAPS_N8  = 8'hB8;
  localparam logic [15:0] TAPS_N16 = 16'hD008;
  localparam logic [31:0] TAPS_N32 = 32'h8020_0003;

  function automatic int clog2(input int value);
    int r;
    r = 0;
    while ((1 << r) < value) r++;
    return r;
  endfunction

endpackage

// File: rtl/rr_arbiter.sv
// Combinational round-robin pick: first set request after index `last`, wrapping modulo NREQ.
module rr_arbiter
  import lfsr_arb_pkg::*;
#(
  parameter int NREQ = 4,
  parameter int GW   = (clog2(NREQ) < 1) ? 1 : clog2(NREQ)
) (
  input  logic [NREQ-1:0] req,
  input  logic [GW-1:0]   last,
  input  logic            enable,
  output logic [GW-1:0]   grant,
  output logic            valid
);

  logic [GW-1:0] idx;

  always_comb begin
    grant = '0;
    valid = 1'b0;
    idx   = '0;
    // Walk farthest-first so the nearest candidate after `last` is the one that sticks.
    for (int i = NREQ; i >= 1; i--) begin
      idx = GW'((int'(last) + i) % NREQ);
      if (enable && req[idx]) begin
        grant = idx;
        valid = 1'b1;
      end
    end
  end

endmodule

// File: rtl/lfsr_rand_arbiter.sv
// Round-robin front end for a shared Fibonacci LFSR; each grant clocks the LFSR W times
// and returns the collected feedback bits as one word with a one-cycle ack.
module lfsr_rand_arbiter
  import lfsr_arb_pkg::*;
#(
  parameter int           NREQ = 4,
  parameter int           N    = 16,
  parameter int           W    = 8,
  parameter logic [N-1:0] TAPS = 16'hD008,
  parameter logic [N-1:0] SEED = N'(1)
) (
  input  logic            clk,
  input  logic            reset_n,
  input  logic [NREQ-1:0] req,
  output logic [NREQ-1:0] ack,
  output logic [W-1:0]    rdata,
  input  logic            seed_we,
  input  logic [N-1:0]    seed,
  output logic            busy,
  output logic            lockup_err
);

  // state | meaning
  // IDLE  | waiting; seed loads and new grants happen here
  // SHIFT | one LFSR step per cycle, W steps in total
  // ACK   | word and one-hot ack presented for exactly one cycle

  localparam int            GW       = (clog2(NREQ) < 1) ? 1 : clog2(NREQ);
  localparam int            CW       = clog2(W + 1);
  localparam logic [CW-1:0] CNT_LAST = CW'(W - 1);
  localparam logic [GW-1:0] LAST_RST = GW'(NREQ - 1);

  state_t        state;
  logic [N-1:0]  lfsr;
  logic [N-1:0]  lfsr_next;
  logic [W-1:0]  rdata_sh;
  logic [W-1:0]  rdata_sh_next;
  logic [W-1:0]  rdata_q;
  logic [CW-1:0] cnt;
  logic [GW-1:0] grant;
  logic [GW-1:0] last;
  logic [GW-1:0] arb_grant;
  logic          arb_valid;
  logic          arb_enable;
  logic          fb;

  // Seed writes win over requests, so the arbiter is held off whenever seed_we is up.
  assign arb_enable = (state == IDLE) && !seed_we;

  rr_arbiter #(
    .NREQ (NREQ),
    .GW   (GW)
  ) u_rr_arbiter (
    .req    (req),
    .last   (last),
    .enable (arb_enable),
    .grant  (arb_grant),
    .valid  (arb_valid)
  );

  assign fb            = ^(lfsr & TAPS);
  assign lfsr_next     = (lfsr << 1) | N'(fb);
  assign rdata_sh_next = (rdata_sh << 1) | W'(fb);

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state      <= IDLE;
      lfsr       <= SEED;
      rdata_sh   <= '0;
      rdata_q    <= '0;
      cnt        <= '0;
      grant      <= '0;
      last       <= LAST_RST;
      lockup_err <= 1'b0;
    end else begin
      lockup_err <= 1'b0;
      case (state)
        IDLE: begin
          if (seed_we) begin
            if (seed == '0) begin
              lfsr       <= SEED;
              lockup_err <= 1'b1;
            end else begin
              lfsr <= seed;
            end
          end else if (arb_valid) begin
            grant <= arb_grant;
            cnt   <= '0;
            state <= SHIFT;
          end
        end
        SHIFT: begin
          lfsr     <= lfsr_next;
          rdata_sh <= rdata_sh_next;
          if (cnt == CNT_LAST) begin
            state <= ACK;
          end else begin
            cnt <= cnt + CW'(1);
          end
        end
        ACK: begin
          rdata_q <= rdata_sh;
          last    <= grant;
          state   <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

  // The finished word is shown straight from the shifter during ACK, then held in rdata_q.
  assign ack   = (state == ACK) ? (NREQ'(1) << grant) : '0;
  assign rdata = (state == ACK) ? rdata_sh : rdata_q;
  assign busy  = (state != IDLE);

endmodule

// File: tb/tb_lfsr_rand_arbiter.sv
// Scoreboard bench for lfsr_rand_arbiter: a transaction-level model predicts each ack
// (requester, word, LFSR state, cycle) and a separate monitor checks the DUT outputs.
module tb_lfsr_rand_arbiter;

  localparam int           NREQ = 4;
  localparam int           N    = 3;
  localparam int           W    = 3;
  localparam logic [N-1:0] TAPS = 3'b110;
  localparam logic [N-1:0] SEED = 3'b001;

  logic            clk = 1'b0;
  logic            reset_n;
  logic [NREQ-1:0] req;
  logic [NREQ-1:0] ack;
  logic [W-1:0]    rdata;
  logic            seed_we;
  logic [N-1:0]    seed;
  logic            busy;
  logic            lockup_err;

  lfsr_rand_arbiter #(
    .NREQ (NREQ),
    .N    (N),
    .W    (W),
    .TAPS (TAPS),
    .SEED (SEED)
  ) dut (
    .clk        (clk),
    .reset_n    (reset_n),
    .req        (req),
    .ack        (ack),
    .rdata      (rdata),
    .seed_we    (seed_we),
    .seed       (seed),
    .busy       (busy),
    .lockup_err (lockup_err)
  );

  always #5 clk = ~clk;

  typedef struct {
    int idx;
    int word;
    int lfsr;
    int cyc;
  } exp_t;

  exp_t exp_q[$];
  exp_t m_push;
  exp_t m_pop;
  int   n_checks   = 0;
  int   n_errors   = 0;
  int   cyc        = 0;
  int   free_at    = 0;
  int   busy_from  = -1;
  int   busy_to    = -1;
  int   lock_cyc   = -1;
  int   m_lfsr     = int'(SEED);
  int   m_last     = NREQ - 1;
  int   m_idx;
  int   m_word;
  int   m_fb;
  int   hold_rdata = 0;

  task automatic chk(input string name, input int act, input int exp);
    n_checks++;
    if (act != exp) begin
      n_errors++;
      $display("FAIL %s: got %0d expected %0d (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  task automatic tick(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic check_reset_outputs();
    chk("rst_ack", int'(ack), 0);
    chk("rst_rdata", int'(rdata), 0);
    chk("rst_busy", int'(busy), 0);
    chk("rst_lockup_err", int'(lockup_err), 0);
    chk("rst_lfsr", int'(dut.lfsr), int'(SEED));
  endtask

  task automatic pulse_reset();
    reset_n = 1'b0;
    #1;
    check_reset_outputs();
    tick(2);
    reset_n = 1'b1;
  endtask

  // Reference model: one decision per rising edge, timing taken from the latency rules.
  initial begin
    forever begin
      @(posedge clk);
      cyc++;
      if (!reset_n) begin
        exp_q.delete();
        m_lfsr    = int'(SEED);
        m_last    = NREQ - 1;
        free_at   = 0;
        busy_from = -1;
        busy_to   = -1;
        lock_cyc  = -1;
      end else if (cyc >= free_at) begin
        if (seed_we) begin
          if (seed == '0) begin
            m_lfsr   = int'(SEED);
            lock_cyc = cyc;
          end else begin
            m_lfsr = int'(seed);
          end
        end else if (req != '0) begin
          m_idx = -1;
          for (int i = 1; i <= NREQ; i++) begin
            if (m_idx < 0 && ((int'(req) >> ((m_last + i) % NREQ)) & 1) == 1)
              m_idx = (m_last + i) % NREQ;
          end
          m_word = 0;
          for (int b = 0; b < W; b++) begin
            m_fb   = $countones(m_lfsr & int'(TAPS)) % 2;
            m_word = m_word * 2 + m_fb;
            m_lfsr = (m_lfsr * 2 + m_fb) % (1 << N);
          end
          m_push.idx  = m_idx;
          m_push.word = m_word;
          m_push.lfsr = m_lfsr;
          m_push.cyc  = cyc + W;
          exp_q.push_back(m_push);
          m_last    = m_idx;
          busy_from = cyc;
          busy_to   = cyc + W;
          free_at   = cyc + W + 2;
        end
      end
    end
  end

  // Monitor: samples on the falling edge, pops an expectation whenever ack is seen.
  initial begin
    forever begin
      @(negedge clk);
      if (!reset_n) begin
        hold_rdata = 0;
      end else begin
        if (ack != '0) begin
          if (exp_q.size() == 0) begin
            n_checks++;
            n_errors++;
            $display("FAIL unexpected_ack: got ack=%b expected none (cycle %0d)", ack, cyc);
          end else begin
            m_pop = exp_q.pop_front();
            chk("ack_onehot", int'(ack), 1 << m_pop.idx);
            chk("ack_rdata", int'(rdata), m_pop.word);
            chk("lfsr_after", int'(dut.lfsr), m_pop.lfsr);
            chk("ack_cycle", cyc, m_pop.cyc);
            hold_rdata = m_pop.word;
          end
        end else begin
          if (exp_q.size() > 0 && cyc > exp_q[0].cyc) begin
            n_checks++;
            n_errors++;
            $display("FAIL ack_missing: got no ack by cycle %0d expected at %0d", cyc, exp_q[0].cyc);
            m_pop = exp_q.pop_front();
          end
          chk("rdata_hold", int'(rdata), hold_rdata);
        end
        chk("busy", int'(busy), (cyc >= busy_from && cyc <= busy_to) ? 1 : 0);
        chk("lockup_err", int'(lockup_err), (cyc == lock_cyc) ? 1 : 0);
      end
    end
  end

  initial begin
    reset_n = 1'b0;
    req     = '0;
    seed_we = 1'b0;
    seed    = '0;
    tick(3);
    check_reset_outputs();
    reset_n = 1'b1;

    // Single requester held through seven grants: full LFSR period.
    req = 4'b0001;
    tick(35);
    req = '0;
    tick(10);

    // All requesters from fresh reset: strict rotation starting at req[0].
    pulse_reset();
    req = 4'b1111;
    tick(25);
    req = '0;
    tick(10);

    // Zero seed together with a request: substitution wins, grant follows.
    seed_we = 1'b1;
    seed    = 3'b000;
    req     = 4'b0010;
    tick(1);
    seed_we = 1'b0;
    tick(4);
    req = '0;
    tick(10);

    // Seed write while busy is dropped; req released mid-shift still completes.
    req = 4'b0001;
    tick(1);
    req     = '0;
    seed_we = 1'b1;
    seed    = 3'b111;
    tick(2);
    seed_we = 1'b0;
    tick(10);

    // Reset in the middle of SHIFT: no ack, priority restarts at req[0].
    req = 4'b0001;
    tick(2);
    req = '0;
    pulse_reset();
    req = 4'b1111;
    tick(1);
    req = '0;
    tick(10);

    for (int c = 0; c < 3000; c++) begin
      req     = ($urandom_range(0, 3) == 0) ? '0 : NREQ'($urandom_range(0, 15));
      seed_we = ($urandom_range(0, 9) == 0);
      seed    = N'($urandom_range(0, 7));
      if ($urandom_range(0, 599) == 0) pulse_reset();
      else tick(1);
    end
    req     = '0;
    seed_we = 1'b0;
    tick(15);
    chk("queue_drained", exp_q.size(), 0);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
